rca_slice_sequencer: RTL and testbench

- Multi-cycle adder/subtractor controller that computes a WIDTH-bit result by reusing one SLICE-bit ripple-carry slice over WIDTH/SLICE cycles.
- Sequences the slice from LSB to MSB and holds the inter-slice carry in a register.
- Trades the full-width ripple path for a short per-cycle path.
- Sits between an operand-issuing controller and the register file; uses a start/done handshake.

---
 rtl/rca_slice_sequencer.sv | 140 ++++++++++++++
 tb/tb_rca_slice_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rca_slice_sequencer.sv
// rca_slice_sequencer
// Multi-cycle adder/subtractor. One SLICE-bit ripple-carry slice is reused
// over WIDTH/SLICE cycles, LSB slice first. The carry between slices is held
// in a register, so each cycle only has a SLICE-bit ripple path.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset, highest priority
//   start - request, sampled only in IDLE
//   a, b  - operands, latched when start is accepted
//   cin   - carry-in for add, ignored when sub=1
//   sub   - 0: a+b+cin, 1: a-b
//   busy  - high while an operation is in RUN or DONE
//   done  - one-cycle pulse, sum/cout/ovf valid
//   sum   - result, held until the next accepted start
//   cout  - carry out of the MSB (for sub, 1 = no borrow)
//   ovf   - two's-complement signed overflow
module rca_slice_sequencer #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [SLICE-1:0] a_sl, b_sl, s_sl;
  logic             c_sl, c_msb;
  logic             last;

  // Returns {carry into MSB, carry out, sum}. The carry into the MSB is
  // recovered from the MSB sum bit, which also works for SLICE=1.
  function automatic logic [SLICE+1:0] slice_add(input logic [SLICE-1:0] x,
                                                 input logic [SLICE-1:0] y,
                                                 input logic             ci);
    logic [SLICE:0] t;
    logic           cm;
    t  = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, ci};
    cm = t[SLICE-1] ^ x[SLICE-1] ^ y[SLICE-1];
    return {cm, t};
  endfunction

  assign last = (idx == LAST_IDX);

  always_comb begin
    a_sl = a_q[idx*SLICE +: SLICE];
    b_sl = b_q[idx*SLICE +: SLICE];
    {c_msb, c_sl, s_sl} = slice_add(a_sl, b_sl, carry);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; done is high for the single DONE cycle
  always_comb begin
    busy = (state == RUN) || (state == DONE);
    done = (state == DONE);
  end

  // Operand latch, carry chain register and result assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtract as a + ~b + 1
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
          end
        end
        RUN: begin
          sum[idx*SLICE +: SLICE] <= s_sl;
          carry <= c_sl;
          if (last) begin
            idx  <= '0;
            cout <= c_sl;
            ovf  <= c_msb ^ c_sl;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_slice_sequencer.sv
// Directed bench for rca_slice_sequencer at default parameters (N=4 slices).
module tb_rca_slice_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] a, b;
  logic        cin, sub;
  logic        busy, done;
  logic [63:0] sum;
  logic        cout, ovf;

  int checks   = 0;
  int failures = 0;

  rca_slice_sequencer #(.WIDTH(64), .SLICE(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sub  (sub),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance edge by edge (sampling #1 after) until done, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done && cyc < 20);
  endtask

  // Issue one operation from IDLE and check latency, result and pulse width.
  task automatic run_op(input string tag, input logic [63:0] ia, input logic [63:0] ib,
                        input logic icin, input logic isub,
                        input logic [63:0] esum, input logic ecout, input logic eovf);
    int cyc;
    @(negedge clk);
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(cyc);
    chk({tag, "_lat"}, 64'(cyc), 64'd4);
    chk({tag, "_sum"}, sum, esum);
    chk({tag, "_cout"}, 64'(cout), 64'(ecout));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eovf));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 64'(done), 64'd0);
    chk({tag, "_hold"}, sum, esum);
  endtask

  initial begin
    int cyc;
    int seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum",  sum,       64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf",  64'(ovf),  64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add11",  64'h1, 64'h1, 1'b0, 1'b0, 64'h2, 1'b0, 1'b0);
    run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    run_op("sovf",   64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("sub57",  64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("sub75",  64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0);
    run_op("mix",    64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0,
           64'h0001_0000_0001_0000, 1'b0, 1'b0);

    // Handshake: start held high, operands changed during RUN.
    @(negedge clk);
    a = 64'd100; b = 64'd23; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 64'd5; b = 64'd6;
    seen = 0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2) begin a = 64'hDEAD; b = 64'hBEEF; sub = 1'b1; end
      if (cyc == 3) begin a = 64'd5; b = 64'd6; sub = 1'b0; end
      if (done) seen++;
    end while (!done && cyc < 20);
    chk("hs_lat", 64'(cyc), 64'd4);
    chk("hs_sum", sum, 64'd123);
    @(posedge clk); #1;
    chk("hs_idle_busy", 64'(busy), 64'd0);
    chk("hs_idle_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("hs_reaccept", 64'(busy), 64'd1);
    chk("hs_cleared", sum, 64'd0);
    wait_done(cyc);
    if (done) seen++;
    chk("hs2_lat", 64'(cyc), 64'd4);
    chk("hs2_sum", sum, 64'd11);
    chk("hs_pulses", 64'(seen), 64'd2);

    // Reset on the second RUN edge aborts the operation.
    @(posedge clk); #1;
    @(negedge clk);
    a = 64'h1234; b = 64'h0; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("ab_partial", sum, 64'h1235);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ab_busy", 64'(busy), 64'd0);
    chk("ab_sum",  sum,       64'd0);
    chk("ab_cout", 64'(cout), 64'd0);
    chk("ab_ovf",  64'(ovf),  64'd0);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("ab_nodone", 64'(seen), 64'd0);

    run_op("post", 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
